// File: rtl/input_debouncer.sv
// input_debouncer: synchronises and debounces five push-buttons and one slide
// switch into the clock domain, with optional one-cycle press pulses.
// Optional feature macro: INPUT_DEBOUNCER_PULSE_EN enables buttons_pressed
// generation; when undefined, buttons_pressed is tied to zero.
module input_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] raw_buttons,
    input  logic       raw_switch,
    output logic [4:0] buttons,
    output logic       switch,
    output logic [4:0] buttons_pressed
);

    localparam int unsigned NCH = 6;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NCH-1:0]   raw_all;
    logic [NCH-1:0]   s1;
    logic [NCH-1:0]   s2;
    logic [NCH-1:0]   stab;
    logic [CNT_W-1:0] cnt [NCH];

    // Channel 5 is the switch; channels 4..0 are the buttons.
    assign raw_all = {raw_switch, raw_buttons};

    // Two-flop synchroniser for every raw pin.
    always_ff @(posedge clock) begin
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw_all;
            s2 <= s1;
        end
    end

    // Per-channel stability counter: accept s2 only after it differs from
    // stab on DEBOUNCE_CYCLES consecutive edges; any agreement clears the count.
    always_ff @(posedge clock) begin
        if (!reset) begin
            stab <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (s2[i] == stab[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stab[i] <= s2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign buttons = stab[4:0];
    assign switch  = stab[5];

`ifdef INPUT_DEBOUNCER_PULSE_EN
    logic [4:0] buttons_q;
    logic [4:0] pressed_q;

    // Registered rising-edge detect on the debounced button levels.
    always_ff @(posedge clock) begin
        if (!reset) begin
            buttons_q <= '0;
            pressed_q <= '0;
        end else begin
            buttons_q <= stab[4:0];
            pressed_q <= stab[4:0] & ~buttons_q;
        end
    end

    assign buttons_pressed = pressed_q;
`else
    assign buttons_pressed = '0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed checks of input_debouncer with DEBOUNCE_CYCLES=4.
// Expected pulse values collapse to zero when INPUT_DEBOUNCER_PULSE_EN is undefined.
module tb_input_debouncer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] raw_buttons = '0;
    logic       raw_switch = 1'b0;
    logic [4:0] buttons;
    logic       switch;
    logic [4:0] buttons_pressed;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    input_debouncer #(.DEBOUNCE_CYCLES(4)) dut (
        .clock           (clock),
        .reset           (reset),
        .raw_buttons     (raw_buttons),
        .raw_switch      (raw_switch),
        .buttons         (buttons),
        .switch          (switch),
        .buttons_pressed (buttons_pressed)
    );

    always #5 clock = ~clock;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] pulse_exp(input logic [4:0] v);
`ifdef INPUT_DEBOUNCER_PULSE_EN
        return v;
`else
        return 5'b0 & v;
`endif
    endfunction

    initial begin
        // Reset held with all inputs high.
        reset       = 1'b0;
        raw_buttons = 5'h1F;
        raw_switch  = 1'b1;
        repeat (3) tick();
        check_eq("rst_buttons", {3'b0, buttons}, 8'h00);
        check_eq("rst_switch", {7'b0, switch}, 8'h00);
        check_eq("rst_pressed", {3'b0, buttons_pressed}, 8'h00);

        // Release: first edge captures s1, acceptance five edges later.
        reset = 1'b1;
        repeat (5) tick();
        check_eq("rel_buttons_pre", {3'b0, buttons}, 8'h00);
        check_eq("rel_switch_pre", {7'b0, switch}, 8'h00);
        tick();
        check_eq("rel_buttons_acc", {3'b0, buttons}, 8'h1F);
        check_eq("rel_switch_acc", {7'b0, switch}, 8'h01);
        check_eq("rel_pressed_acc", {3'b0, buttons_pressed}, 8'h00);
        tick();
        check_eq("rel_pulse", {3'b0, buttons_pressed}, {3'b0, pulse_exp(5'h1F)});
        tick();
        check_eq("rel_pulse_end", {3'b0, buttons_pressed}, 8'h00);

        // Drop everything back to a quiet state.
        raw_buttons = '0;
        raw_switch  = 1'b0;
        repeat (6) tick();
        check_eq("quiet_buttons", {3'b0, buttons}, 8'h00);
        check_eq("quiet_switch", {7'b0, switch}, 8'h00);
        repeat (4) tick();

        // Clean press of button 2.
        raw_buttons = 5'b00100;
        repeat (5) tick();
        check_eq("press_pre", {3'b0, buttons}, 8'h00);
        tick();
        check_eq("press_acc", {3'b0, buttons}, 8'h04);
        check_eq("press_nopulse_yet", {3'b0, buttons_pressed}, 8'h00);
        tick();
        check_eq("press_pulse", {3'b0, buttons_pressed}, {3'b0, pulse_exp(5'b00100)});
        tick();
        check_eq("press_pulse_end", {3'b0, buttons_pressed}, 8'h00);

        // Release of button 2: level drops, no pulse.
        raw_buttons = '0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_eq($sformatf("rls_hold%0d", k), {3'b0, buttons}, 8'h04);
            check_eq($sformatf("rls_nopulse%0d", k), {3'b0, buttons_pressed}, 8'h00);
        end
        tick();
        check_eq("rls_acc", {3'b0, buttons}, 8'h00);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_eq($sformatf("rls_after%0d", k), {3'b0, buttons_pressed}, 8'h00);
        end

        // Bounce on button 0: high 3, low 1, high 3, low.
        for (int k = 0; k < 16; k++) begin
            raw_buttons[0] = (k < 3) || (k >= 4 && k < 7);
            tick();
            check_eq($sformatf("bounce_lvl%0d", k), {3'b0, buttons}, 8'h00);
            check_eq($sformatf("bounce_pls%0d", k), {3'b0, buttons_pressed}, 8'h00);
        end

        // Switch and button 4 rise together.
        raw_buttons = 5'b10000;
        raw_switch  = 1'b1;
        repeat (5) tick();
        check_eq("sim_btn_pre", {3'b0, buttons}, 8'h00);
        check_eq("sim_sw_pre", {7'b0, switch}, 8'h00);
        tick();
        check_eq("sim_btn_acc", {3'b0, buttons}, 8'h10);
        check_eq("sim_sw_acc", {7'b0, switch}, 8'h01);
        tick();
        check_eq("sim_pulse", {3'b0, buttons_pressed}, {3'b0, pulse_exp(5'b10000)});
        tick();
        check_eq("sim_pulse_end", {3'b0, buttons_pressed}, 8'h00);
        raw_buttons = '0;
        raw_switch  = 1'b0;
        repeat (8) tick();
        check_eq("sim_rls_btn", {3'b0, buttons}, 8'h00);
        check_eq("sim_rls_sw", {7'b0, switch}, 8'h00);

        // Reset mid-count on button 1.
        raw_buttons = 5'b00010;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check_eq("mid_rst_btn", {3'b0, buttons}, 8'h00);
        reset = 1'b1;
        repeat (5) tick();
        check_eq("mid_pre", {3'b0, buttons}, 8'h00);
        tick();
        check_eq("mid_acc", {3'b0, buttons}, 8'h02);
        tick();
        check_eq("mid_pulse", {3'b0, buttons_pressed}, {3'b0, pulse_exp(5'b00010)});
        tick();
        check_eq("mid_pulse_end", {3'b0, buttons_pressed}, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
